instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 35 +++
 rtl/instr_sequencer_op_timeout_lut.sv | 32 +++
 rtl/instr_sequencer.sv | 132 +++++++++++++
 tb/tb_instr_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
// Contents:
//   - opcode constants (the value found in instruction[31:26])
//   - sequencer state encoding
//   - error code constants
//   - opcode_of(): extracts the opcode field from an instruction word
package instr_sequencer_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_MUL   = 6'd2;
  localparam logic [5:0] OP_EAST  = 6'd5;
  localparam logic [5:0] OP_WEST  = 6'd6;
  localparam logic [5:0] OP_SOUTH = 6'd7;
  localparam logic [5:0] OP_NORTH = 6'd8;
  localparam logic [5:0] OP_9     = 6'd9;
  localparam logic [5:0] OP_10    = 6'd10;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_MEM = 3'd2;
  localparam logic [2:0] ST_ISSUE    = 3'd3;
  localparam logic [2:0] ST_EXEC     = 3'd4;
  localparam logic [2:0] ST_HALT     = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/instr_sequencer_op_timeout_lut.sv
// op_timeout_lut: combinational map from opcode to the nominal number of
// execution cycles for an operand length of LENGTH bits.
// Ports:
//   opcode  in   6  opcode field of the instruction
//   cycles  out 32  nominal cycle count (0 for opcodes that are not legal)
//   legal   out  1  high when the opcode is one the controller can execute
module op_timeout_lut
  import instr_sequencer_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic [5:0]  opcode,
  output logic [31:0] cycles,
  output logic        legal
);

  localparam logic [31:0] CYC_ALU  = 32'(2 * LENGTH + 2);
  localparam logic [31:0] CYC_MUL  = 32'((LENGTH + 1) * (2 * LENGTH + 6));
  localparam logic [31:0] CYC_MOVE = 32'(LENGTH + 2);

  always_comb begin
    cycles = '0;
    legal  = 1'b1;
    case (opcode)
      OP_ADD, OP_SUB, OP_9, OP_10:          cycles = CYC_ALU;
      OP_MUL:                               cycles = CYC_MUL;
      OP_EAST, OP_WEST, OP_SOUTH, OP_NORTH: cycles = CYC_MOVE;
      default:                              legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 32-bit instructions from a synchronous instruction
// memory, decodes the opcode, launches a downstream controller with a one-cycle
// start pulse and guards each execution with an opcode-dependent watchdog.
// Ports:
//   clk          in   1       rising-edge clock
//   reset        in   1       asynchronous, active-low reset
//   run          in   1       start a program at address 0 (honoured in IDLE/HALT)
//   imem_addr    out  ADDR_W  instruction memory read address
//   imem_rdata   in   32      instruction memory data, one cycle after imem_addr
//   instruction  out  32      instruction word held for the controller
//   start        out  1       one-cycle launch pulse for the controller
//   exec_done    in   1       controller completion pulse
//   busy         out  1       high outside IDLE and HALT
//   halted       out  1       high in HALT
//   pc           out  ADDR_W  address of the instruction being executed
//   instr_count  out  16      completed instructions, saturating
//   err          out  2       0 none, 1 illegal opcode, 2 timeout
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int LENGTH         = 32,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_MARGIN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic              start,
  input  logic              exec_done,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count,
  output logic [1:0]        err
);

  logic [2:0]        state;
  logic [31:0]       watchdog;
  logic [5:0]        opcode;
  logic [31:0]       nominal;
  logic              legal;
  logic [ADDR_W-1:0] pc_next;

  // In WAIT_MEM the new word is still on imem_rdata; from ISSUE on it is
  // held in instruction, so the decoder looks at whichever is current.
  assign opcode  = (state == ST_WAIT_MEM) ? opcode_of(imem_rdata) : opcode_of(instruction);
  assign pc_next = pc + ADDR_W'(1);

  assign busy   = (state != ST_IDLE) && (state != ST_HALT);
  assign halted = (state == ST_HALT);

  op_timeout_lut #(
    .LENGTH (LENGTH)
  ) u_lut (
    .opcode (opcode),
    .cycles (nominal),
    .legal  (legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      imem_addr   <= '0;
      instruction <= '0;
      instr_count <= '0;
      err         <= ERR_NONE;
      watchdog    <= '0;
      start       <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: begin
          if (run) begin
            // imem_addr follows pc so the synchronous memory already sees the
            // right address during FETCH.
            pc          <= '0;
            imem_addr   <= '0;
            instr_count <= '0;
            err         <= ERR_NONE;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          imem_addr <= pc;
          state     <= ST_WAIT_MEM;
        end
        ST_WAIT_MEM: begin
          instruction <= imem_rdata;
          if (opcode == OP_HALT) begin
            err   <= ERR_NONE;
            state <= ST_HALT;
          end else if (!legal) begin
            err   <= ERR_ILLEGAL;
            state <= ST_HALT;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start    <= 1'b1;
          watchdog <= nominal + 32'(TIMEOUT_MARGIN);
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          // Completion wins over expiry when both land on the same edge.
          // Expiry fires on the edge that takes the watchdog from 1 to 0.
          if (exec_done) begin
            if (instr_count != 16'hFFFF) begin
              instr_count <= instr_count + 16'd1;
            end
            pc        <= pc_next;
            imem_addr <= pc_next;
            watchdog  <= '0;
            state     <= ST_FETCH;
          end else if (watchdog <= 32'd1) begin
            watchdog <= '0;
            err      <= ERR_TIMEOUT;
            state    <= ST_HALT;
          end else begin
            watchdog <= watchdog - 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  localparam int LEN = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        start;
  logic        exec_done;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;
  logic [15:0] instr_count;
  logic [1:0]  err;

  logic        run2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_rdata2;
  logic [31:0] instruction2;
  logic        start2;
  logic        exec_done2;
  logic        busy2;
  logic        halted2;
  logic [1:0]  pc2;
  logic [15:0] count2;
  logic [1:0]  err2;

  logic [31:0] mem  [0:255];
  logic [31:0] mem2 [0:3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_sequencer u_dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .start       (start),
    .exec_done   (exec_done),
    .busy        (busy),
    .halted      (halted),
    .pc          (pc),
    .instr_count (instr_count),
    .err         (err)
  );

  instr_sequencer #(.ADDR_W(2)) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .run         (run2),
    .imem_addr   (imem_addr2),
    .imem_rdata  (imem_rdata2),
    .instruction (instruction2),
    .start       (start2),
    .exec_done   (exec_done2),
    .busy        (busy2),
    .halted      (halted2),
    .pc          (pc2),
    .instr_count (count2),
    .err         (err2)
  );

  // synchronous instruction memories: data one cycle after the address
  always @(posedge clk) imem_rdata  <= mem[imem_addr];
  always @(posedge clk) imem_rdata2 <= mem2[imem_addr2];

  // ---------------- behavioural model (event/timestamp based) ----------------
  bit          m_start  = 1'b0;
  bit          m_busy   = 1'b0;
  bit          m_halted = 1'b0;
  logic [7:0]  m_pc     = '0;
  logic [15:0] m_count  = '0;
  logic [1:0]  m_err    = '0;
  logic [31:0] m_instr  = '0;
  int          m_edge   = 0;
  int          decode_at = -1;
  int          issue_at  = -1;
  int          deadline  = -1;
  bit          in_exec   = 1'b0;

  function automatic int nominal_cycles(input int op);
    if (op inside {0, 1, 9, 10}) return 2 * LEN + 2;
    if (op == 2) return (LEN + 1) * (2 * LEN + 6);
    if (op inside {[5:8]}) return LEN + 2;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    int e;
    int op;
    if (!reset) begin
      m_start = 1'b0; m_busy = 1'b0; m_halted = 1'b0;
      m_pc = '0; m_count = '0; m_err = '0; m_instr = '0;
      decode_at = -1; issue_at = -1; deadline = -1; in_exec = 1'b0;
    end else begin
      e = m_edge + 1;
      m_edge = e;
      m_start = 1'b0;
      if (in_exec) begin
        if (exec_done) begin
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          m_pc = m_pc + 8'd1;
          in_exec = 1'b0;
          decode_at = e + 2;
        end else if (e == deadline) begin
          m_err = 2'd2; m_halted = 1'b1; m_busy = 1'b0; in_exec = 1'b0;
        end
      end else if (m_busy && e == decode_at) begin
        m_instr = mem[m_pc];
        op = int'(m_instr[31:26]);
        if (op == 63) begin
          m_halted = 1'b1; m_busy = 1'b0;
        end else if (nominal_cycles(op) < 0) begin
          m_err = 2'd1; m_halted = 1'b1; m_busy = 1'b0;
        end else begin
          issue_at = e + 1;
          deadline = e + 1 + nominal_cycles(op) + 16;
        end
      end else if (m_busy && e == issue_at) begin
        m_start = 1'b1;
        in_exec = 1'b1;
      end else if (!m_busy && run) begin
        m_pc = '0; m_count = '0; m_err = '0;
        m_halted = 1'b0; m_busy = 1'b1;
        decode_at = e + 2;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, m_edge, act, exp);
    end
  endtask

  // advance one cycle and compare every output with the model
  task automatic step();
    @(negedge clk);
    check("cyc_start",  32'(start),       32'(m_start));
    check("cyc_busy",   32'(busy),        32'(m_busy));
    check("cyc_halted", 32'(halted),      32'(m_halted));
    check("cyc_pc",     32'(pc),          32'(m_pc));
    check("cyc_count",  32'(instr_count), 32'(m_count));
    check("cyc_err",    32'(err),         32'(m_err));
    check("cyc_instr",  instruction,      m_instr);
  endtask

  task automatic pulse_run(output int sample_edge);
    run = 1'b1;
    step();
    run = 1'b0;
    sample_edge = m_edge;
  endtask

  task automatic wait_start(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_halt(input int bound, output bit ok, output int nstart);
    ok = 1'b0;
    nstart = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (start) nstart++;
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic done_pulse();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit reached at edge %0d", m_edge);
    $fatal(1);
  end

  initial begin
    int e0;
    int l_edge;
    int ns;
    bit ok;

    reset = 1'b0; run = 1'b0; exec_done = 1'b0; run2 = 1'b0; exec_done2 = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 32'hFC00_0000;
    for (int a = 0; a < 4; a++) mem2[a] = {6'd0, 26'(a * 5 + 1)};

    // reset state
    repeat (3) step();
    check("rst_busy",      32'(busy), 0);
    check("rst_halted",    32'(halted), 0);
    check("rst_pc",        32'(pc), 0);
    check("rst_count",     32'(instr_count), 0);
    check("rst_err",       32'(err), 0);
    check("rst_start",     32'(start), 0);
    check("rst_instr",     instruction, 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    reset = 1'b1;
    repeat (2) step();

    // program [ADD, SUB, HALT], exec_done 66 cycles after each start
    mem[0] = 32'h0000_0123;
    mem[1] = 32'h0400_0456;
    mem[2] = 32'hFC00_0000;
    pulse_run(e0);
    wait_start(10, ok);
    check("p1_start0_seen", 32'(ok), 1);
    check("p1_run_latency", 32'(m_edge - e0), 3);
    check("p1_instr0",      instruction, 32'h0000_0123);
    repeat (65) step();
    done_pulse();
    e0 = m_edge;
    wait_start(10, ok);
    check("p1_start1_seen", 32'(ok), 1);
    check("p1_done_latency", 32'(m_edge - e0), 3);
    check("p1_pc1",    32'(pc), 1);
    check("p1_count1", 32'(instr_count), 1);
    check("p1_instr1", instruction, 32'h0400_0456);
    repeat (65) step();
    done_pulse();
    wait_halt(10, ok, ns);
    check("p1_halt_seen",    32'(ok), 1);
    check("p1_extra_starts", 32'(ns), 0);
    check("p1_count_final",  32'(instr_count), 2);
    check("p1_halted",       32'(halted), 1);
    check("p1_err",          32'(err), 0);
    check("p1_busy",         32'(busy), 0);

    // illegal opcode 3, started from HALT
    mem[0] = 32'h0C00_0000;
    pulse_run(e0);
    wait_halt(10, ok, ns);
    check("p2_halt_seen", 32'(ok), 1);
    check("p2_no_start",  32'(ns), 0);
    check("p2_err",       32'(err), 1);
    check("p2_halted",    32'(halted), 1);
    check("p2_pc",        32'(pc), 0);

    // MUL with exec_done withheld: timeout 33*70+16 = 2326 cycles after load
    mem[0] = 32'h0800_0000;
    pulse_run(e0);
    wait_start(10, ok);
    check("p3_start_seen", 32'(ok), 1);
    l_edge = m_edge;
    repeat (2325) step();
    check("p3_err_before",    32'(err), 0);
    check("p3_halted_before", 32'(halted), 0);
    step();
    check("p3_elapsed",      32'(m_edge - l_edge), 2326);
    check("p3_err_timeout",  32'(err), 2);
    check("p3_halted_after", 32'(halted), 1);
    check("p3_count",        32'(instr_count), 0);

    // EAST: run during EXEC ignored, exec_done on the last allowed edge (34+16)
    mem[0] = 32'h1400_0000;
    mem[1] = 32'hFC00_0000;
    pulse_run(e0);
    wait_start(10, ok);
    check("p4_start_seen", 32'(ok), 1);
    l_edge = m_edge;
    repeat (5) step();
    run = 1'b1;
    step();
    run = 1'b0;
    repeat (3) step();
    check("p4_pc_kept",    32'(pc), 0);
    check("p4_count_kept", 32'(instr_count), 0);
    check("p4_busy",       32'(busy), 1);
    repeat (40) step();
    done_pulse();
    check("p4_done_edge",  32'(m_edge - l_edge), 50);
    check("p4_err_none",   32'(err), 0);
    check("p4_count",      32'(instr_count), 1);
    check("p4_pc",         32'(pc), 1);
    wait_halt(10, ok, ns);
    check("p4_halt_seen",  32'(ok), 1);
    done_pulse();
    step();
    check("p4_done_ignored", 32'(instr_count), 1);

    // reset 10 cycles into EXEC, then restart
    mem[0] = 32'h2000_0000;
    pulse_run(e0);
    wait_start(10, ok);
    check("p5_start_seen", 32'(ok), 1);
    repeat (10) step();
    #2 reset = 1'b0;
    #1;
    check("p5_rst_busy",   32'(busy), 0);
    check("p5_rst_halted", 32'(halted), 0);
    check("p5_rst_pc",     32'(pc), 0);
    check("p5_rst_count",  32'(instr_count), 0);
    check("p5_rst_err",    32'(err), 0);
    check("p5_rst_start",  32'(start), 0);
    check("p5_rst_instr",  instruction, 0);
    check("p5_rst_addr",   32'(imem_addr), 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    pulse_run(e0);
    wait_start(10, ok);
    check("p5_restart_seen",    32'(ok), 1);
    check("p5_restart_latency", 32'(m_edge - e0), 3);
    check("p5_restart_pc",      32'(pc), 0);
    check("p5_restart_instr",   instruction, 32'h2000_0000);
    repeat (3) step();
    done_pulse();
    wait_halt(10, ok, ns);
    check("p5_halt_seen", 32'(ok), 1);
    check("p5_count",     32'(instr_count), 1);

    // ADDR_W=2: pc wraps 3 -> 0 and the count runs past 4
    run2 = 1'b1;
    step();
    run2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ok = 1'b0;
      for (int j = 0; j < 10; j++) begin
        step();
        if (start2) begin
          ok = 1'b1;
          break;
        end
      end
      check("wrap_start_seen", 32'(ok), 1);
      check("wrap_pc",    32'(pc2), 32'(k % 4));
      check("wrap_instr", instruction2, mem2[k % 4]);
      repeat (4) step();
      exec_done2 = 1'b1;
      step();
      exec_done2 = 1'b0;
      check("wrap_count", 32'(count2), 32'(k + 1));
    end
    check("wrap_err",    32'(err2), 0);
    check("wrap_busy",   32'(busy2), 1);
    check("wrap_halted", 32'(halted2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
